// File: rtl/button_event_decoder_if.sv
// Button-level input and classified event pulses between the debouncer, the decoder and the UI logic.
interface button_event_decoder_if;
    logic       btn_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       dclick_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic [2:0] state_o;

    modport master (
        output btn_in,
        input  press_pulse, release_pulse, click_pulse, dclick_pulse,
        input  long_pulse, repeat_pulse, state_o
    );

    modport slave (
        input  btn_in,
        output press_pulse, release_pulse, click_pulse, dclick_pulse,
        output long_pulse, repeat_pulse, state_o
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies the debounced button level into registered one-clock event pulses.
// state  | meaning
// IDLE   | released, no gesture in progress
// PRESS1 | first press held, timing towards long press
// WAIT2  | first press released, timing the double-click gap
// PRESS2 | second press held; ends at release without further events
// HOLD   | long press reached, emitting auto-repeat pulses
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 15_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    button_event_decoder_if.slave    bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_WAIT2  = 3'd2;
    localparam logic [2:0] S_PRESS2 = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_btn_prev;
    logic             r_press;
    logic             r_release;
    logic             r_click;
    logic             r_dclick;
    logic             r_long;
    logic             r_repeat;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_press;
    logic             w_release;
    logic             w_click;
    logic             w_dclick;
    logic             w_long;
    logic             w_repeat;

    assign w_rise = bus.btn_in & ~r_btn_prev;
    assign w_fall = ~bus.btn_in & r_btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_btn_prev <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_click    <= 1'b0;
            r_dclick   <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_btn_prev <= bus.btn_in;
            r_press    <= w_press;
            r_release  <= w_release;
            r_click    <= w_click;
            r_dclick   <= w_dclick;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
        end
    end

    // Edges always win over a timer expiring in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_nxt = S_PRESS1;
            end
            S_PRESS1: begin
                if (w_fall)
                    w_state_nxt = S_WAIT2;
                else if (bus.btn_in && (r_timer == LONG_LAST))
                    w_state_nxt = S_HOLD;
                else
                    w_timer_nxt = r_timer + CNT_ONE;
            end
            S_WAIT2: begin
                if (w_rise)
                    w_state_nxt = S_PRESS2;
                else if (r_timer == DCLICK_LAST)
                    w_state_nxt = S_IDLE;
                else
                    w_timer_nxt = r_timer + CNT_ONE;
            end
            S_PRESS2: begin
                if (w_fall) w_state_nxt = S_IDLE;
            end
            S_HOLD: begin
                if (w_fall)
                    w_state_nxt = S_IDLE;
                else if (r_timer != REPEAT_LAST)
                    w_timer_nxt = r_timer + CNT_ONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_press   = w_rise;
        w_release = w_fall;
        w_click   = 1'b0;
        w_dclick  = 1'b0;
        w_long    = 1'b0;
        w_repeat  = 1'b0;
        case (r_state)
            S_PRESS1: w_long   = bus.btn_in && !w_fall && (r_timer == LONG_LAST);
            S_WAIT2: begin
                w_dclick = w_rise;
                w_click  = !w_rise && (r_timer == DCLICK_LAST);
            end
            S_HOLD:   w_repeat = !w_fall && (r_timer == REPEAT_LAST);
            default: begin
                w_click  = 1'b0;
            end
        endcase
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.click_pulse   = r_click;
    assign bus.dclick_pulse  = r_dclick;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.state_o       = r_state;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timer parameters (LONG=8, DCLICK=5, REPEAT=3).
module tb_button_event_decoder;

    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] R = 6'b010000;
    localparam logic [5:0] C = 6'b001000;
    localparam logic [5:0] D = 6'b000100;
    localparam logic [5:0] L = 6'b000010;
    localparam logic [5:0] Q = 6'b000001;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .LONG_CYCLES   (8),
        .DCLICK_CYCLES (5),
        .REPEAT_CYCLES (3),
        .CNT_W         (26)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {bus.press_pulse, bus.release_pulse, bus.click_pulse,
                bus.dclick_pulse, bus.long_pulse, bus.repeat_pulse};
    endfunction

    // Drive btn_in for the next edge, then sample just after it.
    task automatic tick(input logic b);
        bus.btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 6'b0 || bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset: got pulses=%b state=%0d, expected pulses=000000 state=0", obs(), bus.state_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
        checks++;
        if (obs() !== 6'b0 || bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: got pulses=%b state=%0d, expected pulses=000000 state=0", obs(), bus.state_o);
        end
    endtask

    task automatic test_click();
        logic [5:0] exp;
        for (int i = 0; i < 13; i++) begin
            tick(i < 3);
            case (i)
                0:       exp = P;
                3:       exp = R;
                8:       exp = C;
                default: exp = 6'b0;
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL click step %0d: got %b expected %b", i, obs(), exp);
            end
            if (i == 3) begin
                checks++;
                if (bus.state_o !== 3'd2) begin
                    errors++;
                    $display("FAIL click_wait2_state: got %0d expected 2", bus.state_o);
                end
            end
        end
        checks++;
        if (bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL click_end_state: got %0d expected 0", bus.state_o);
        end
    endtask

    task automatic test_dclick();
        logic [5:0] exp;
        for (int i = 0; i < 15; i++) begin
            tick(i == 0 || i == 1 || i == 4 || i == 5);
            case (i)
                0:       exp = P;
                2:       exp = R;
                4:       exp = P | D;
                6:       exp = R;
                default: exp = 6'b0;
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL dclick step %0d: got %b expected %b", i, obs(), exp);
            end
            if (i == 4) begin
                checks++;
                if (bus.state_o !== 3'd3) begin
                    errors++;
                    $display("FAIL dclick_press2_state: got %0d expected 3", bus.state_o);
                end
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [5:0] exp;
        int         n_rep;
        n_rep = 0;
        for (int i = 0; i < 28; i++) begin
            tick(i <= 20);
            case (i)
                0:              exp = P;
                8:              exp = L;
                11, 14, 17, 20: exp = Q;
                21:             exp = R;
                default:        exp = 6'b0;
            endcase
            if (bus.repeat_pulse === 1'b1) n_rep++;
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL long step %0d: got %b expected %b", i, obs(), exp);
            end
            if (i == 9) begin
                checks++;
                if (bus.state_o !== 3'd4) begin
                    errors++;
                    $display("FAIL long_hold_state: got %0d expected 4", bus.state_o);
                end
            end
        end
        checks++;
        if (n_rep != 4 || bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL long_summary: got repeats=%0d state=%0d expected repeats=4 state=0", n_rep, bus.state_o);
        end
    endtask

    task automatic test_long_boundary();
        logic [5:0] exp;
        for (int i = 0; i < 15; i++) begin
            tick(i < 8);
            case (i)
                0:       exp = P;
                8:       exp = R;
                13:      exp = C;
                default: exp = 6'b0;
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL long_boundary step %0d: got %b expected %b", i, obs(), exp);
            end
            if (i == 8) begin
                checks++;
                if (bus.state_o !== 3'd2) begin
                    errors++;
                    $display("FAIL long_boundary_state: got %0d expected 2", bus.state_o);
                end
            end
        end
    endtask

    task automatic test_gap_boundary();
        logic [5:0] exp;
        for (int i = 0; i < 16; i++) begin
            tick(i == 0 || i == 1 || i == 7 || i == 8);
            case (i)
                0:       exp = P;
                2:       exp = R;
                7:       exp = P | D;
                9:       exp = R;
                default: exp = 6'b0;
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL gap_boundary step %0d: got %b expected %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        for (int i = 0; i < 13; i++) begin
            tick(i == 0 || i == 2 || i == 4);
            case (i)
                0:       exp = P;
                1:       exp = R;
                2:       exp = P | D;
                3:       exp = R;
                4:       exp = P;
                5:       exp = R;
                10:      exp = C;
                default: exp = 6'b0;
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL triple step %0d: got %b expected %b", i, obs(), exp);
            end
            if (i == 4) begin
                checks++;
                if (bus.state_o !== 3'd1) begin
                    errors++;
                    $display("FAIL triple_press1_state: got %0d expected 1", bus.state_o);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            case (i)
                0:       exp = P;
                8:       exp = L;
                11:      exp = Q;
                default: exp = 6'b0;
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL areset_pre step %0d: got %b expected %b", i, obs(), exp);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 6'b0 || bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL areset_immediate: got pulses=%b state=%0d expected pulses=000000 state=0", obs(), bus.state_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        checks++;
        if (obs() !== P || bus.state_o !== 3'd1) begin
            errors++;
            $display("FAIL areset_press: got pulses=%b state=%0d expected pulses=%b state=1", obs(), bus.state_o, P);
        end
        tick(1'b1);
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL areset_after: got %b expected 000000", obs());
        end
        for (int i = 0; i < 8; i++) tick(1'b0);
        checks++;
        if (bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL areset_end_state: got %0d expected 0", bus.state_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.btn_in = 1'b0;
        test_reset();
        test_click();
        test_dclick();
        test_long_repeat();
        test_long_boundary();
        test_gap_boundary();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
